// File: rtl/tug_of_war_field_if.sv
// Key/display bundle for the tug-of-war track.
// master drives keys and restart, slave drives the track display and scores.
interface tug_of_war_field_if #(
   parameter int NUM_LIGHTS = 9,
   parameter int SCORE_W    = 3
);
   logic                  res;
   logic                  L;
   logic                  R;
   logic [NUM_LIGHTS-1:0] lights;
   logic                  left_win;
   logic                  right_win;
   logic [SCORE_W-1:0]    left_score;
   logic [SCORE_W-1:0]    right_score;

   modport master (
      output res, L, R,
      input  lights, left_win, right_win,
      input  left_score, right_score
   );

   modport slave (
      input  res, L, R,
      output lights, left_win, right_win,
      output left_score, right_score
   );
endinterface

// File: rtl/tug_of_war_field.sv
// N-light tug-of-war track with win detection and saturating scores.
// Define TOW_KEY_EDGE_EN to turn key levels into rising-edge move events.
module tug_of_war_field #(
   parameter int NUM_LIGHTS = 9,
   parameter int SCORE_W    = 3
) (
   input  logic clk,
   input  logic reset,
   tug_of_war_field_if.slave bus
);
   localparam int PW = $clog2(NUM_LIGHTS);
   localparam logic [PW-1:0] CENTER =
      PW'((NUM_LIGHTS - 1) / 2);
   localparam logic [PW-1:0] LAST =
      PW'(NUM_LIGHTS - 1);
   localparam logic [SCORE_W-1:0] SMAX = '1;

   typedef enum logic [1:0] {
      PLAY,
      LWIN,
      RWIN
   } state_t;

   state_t                state;
   logic [PW-1:0]         pos;
   logic [NUM_LIGHTS-1:0] lights_q;
   logic                  lw_q;
   logic                  rw_q;
   logic [SCORE_W-1:0]    ls_q;
   logic [SCORE_W-1:0]    rs_q;
   logic                  l_ev;
   logic                  r_ev;
   logic                  mv_l;
   logic                  mv_r;

   function automatic logic [NUM_LIGHTS-1:0]
      onehot(input logic [PW-1:0] p);
      logic [NUM_LIGHTS-1:0] v;
      v    = '0;
      v[p] = 1'b1;
      return v;
   endfunction

`ifdef TOW_KEY_EDGE_EN
   logic l_q;
   logic r_q;
   logic live;

   // live suppresses events on the first edge after reset,
   // so a key already held at release does not count.
   always_ff @(posedge clk) begin
      if (!reset) begin
         l_q  <= 1'b0;
         r_q  <= 1'b0;
         live <= 1'b0;
      end else begin
         l_q  <= bus.L;
         r_q  <= bus.R;
         live <= 1'b1;
      end
   end

   assign l_ev = live & bus.L & ~l_q;
   assign r_ev = live & bus.R & ~r_q;
`else
   assign l_ev = bus.L;
   assign r_ev = bus.R;
`endif

   assign mv_l = l_ev & ~r_ev;
   assign mv_r = r_ev & ~l_ev;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= PLAY;
         pos      <= CENTER;
         lights_q <= onehot(CENTER);
         lw_q     <= 1'b0;
         rw_q     <= 1'b0;
         ls_q     <= '0;
         rs_q     <= '0;
      end else if (bus.res) begin
         state    <= PLAY;
         pos      <= CENTER;
         lights_q <= onehot(CENTER);
         lw_q     <= 1'b0;
         rw_q     <= 1'b0;
      end else begin
         unique case (state)
            PLAY: begin
               unique case (1'b1)
                  mv_l: begin
                     if (pos == LAST) begin
                        state    <= LWIN;
                        lights_q <= '0;
                        lw_q     <= 1'b1;
                        if (ls_q != SMAX)
                           ls_q <= ls_q + 1'b1;
                     end else begin
                        pos      <= pos + 1'b1;
                        lights_q <= onehot(pos + 1'b1);
                     end
                  end
                  mv_r: begin
                     if (pos == '0) begin
                        state    <= RWIN;
                        lights_q <= '0;
                        rw_q     <= 1'b1;
                        if (rs_q != SMAX)
                           rs_q <= rs_q + 1'b1;
                     end else begin
                        pos      <= pos - 1'b1;
                        lights_q <= onehot(pos - 1'b1);
                     end
                  end
                  default: ;
               endcase
            end
            LWIN, RWIN: ;
            default: begin
               state    <= PLAY;
               pos      <= CENTER;
               lights_q <= onehot(CENTER);
               lw_q     <= 1'b0;
               rw_q     <= 1'b0;
            end
         endcase
      end
   end

   assign bus.lights      = lights_q;
   assign bus.left_win    = lw_q;
   assign bus.right_win   = rw_q;
   assign bus.left_score  = ls_q;
   assign bus.right_score = rs_q;
endmodule

// File: tb/tb_tug_of_war_field.sv
// Random and directed checks of tug_of_war_field against a track model.
// The model follows TOW_KEY_EDGE_EN the same way the design does.
module tb_tug_of_war_field;
   localparam int NL   = 9;
   localparam int SW   = 2;
   localparam int C    = (NL - 1) / 2;
   localparam int SMAX = (1 << SW) - 1;

   logic clk = 1'b0;
   logic reset;

   tug_of_war_field_if #(
      .NUM_LIGHTS(NL),
      .SCORE_W(SW)
   ) bus ();

   tug_of_war_field #(
      .NUM_LIGHTS(NL),
      .SCORE_W(SW)
   ) u_dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // 0 = playing, 1 = left won, 2 = right won
   int m_pos   = C;
   int m_st    = 0;
   int m_ls    = 0;
   int m_rs    = 0;
   bit m_pl    = 0;
   bit m_pr    = 0;
   bit m_live  = 0;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h expected %0h",
                  tag, got, exp);
      end
   endtask

   task automatic model(input bit rst, input bit rs,
                        input bit l, input bit r);
      bit el;
      bit er;
      if (!rst) begin
         m_pos  = C;
         m_st   = 0;
         m_ls   = 0;
         m_rs   = 0;
         m_pl   = 0;
         m_pr   = 0;
         m_live = 0;
         return;
      end
`ifdef TOW_KEY_EDGE_EN
      el     = m_live && l && !m_pl;
      er     = m_live && r && !m_pr;
      m_pl   = l;
      m_pr   = r;
      m_live = 1;
`else
      el = l;
      er = r;
`endif
      if (rs) begin
         m_pos = C;
         m_st  = 0;
      end else if (m_st == 0 && el != er) begin
         if (el) begin
            if (m_pos == NL - 1) begin
               m_st = 1;
               if (m_ls < SMAX) m_ls++;
            end else m_pos++;
         end else begin
            if (m_pos == 0) begin
               m_st = 2;
               if (m_rs < SMAX) m_rs++;
            end else m_pos--;
         end
      end
   endtask

   task automatic step(input bit rst, input bit rs,
                       input bit l, input bit r);
      logic [31:0] exp_l;
      @(negedge clk);
      reset   = rst;
      bus.res = rs;
      bus.L   = l;
      bus.R   = r;
      @(posedge clk);
      model(rst, rs, l, r);
      #1;
      exp_l = (m_st == 0) ? (32'd1 << m_pos) : 32'd0;
      check("lights", 32'(bus.lights), exp_l);
      check("left_win", 32'(bus.left_win),
            32'(m_st == 1));
      check("right_win", 32'(bus.right_win),
            32'(m_st == 2));
      check("left_score", 32'(bus.left_score),
            32'(m_ls));
      check("right_score", 32'(bus.right_score),
            32'(m_rs));
   endtask

   task automatic hold(input bit l, input bit r,
                       input int n);
      for (int i = 0; i < n; i++) step(1, 0, l, r);
   endtask

   initial begin
      reset   = 1'b0;
      bus.res = 1'b0;
      bus.L   = 1'b0;
      bus.R   = 1'b0;
      step(0, 0, 0, 0);
      hold(0, 0, 3);
      check("center_const", 32'(bus.lights), 32'h010);
      // march left to a win, then keys are ignored
      hold(1, 0, 6);
      hold(0, 1, 3);
      hold(1, 1, 2);
      // tie from centre, then a right win and restart
      step(1, 1, 0, 0);
      hold(1, 1, 3);
      hold(0, 1, 7);
      step(1, 1, 0, 1);
      // repeated left wins drive the score to saturation
      for (int k = 0; k < 4; k++) begin
         hold(1, 0, 6);
         step(1, 1, 0, 0);
         hold(0, 0, 1);
      end
      // reset mid-round
      hold(1, 0, 3);
      step(0, 0, 1, 0);
      hold(1, 0, 6);
      step(1, 1, 0, 0);
      for (int i = 0; i < 4000; i++) begin
         step($urandom_range(0, 499) != 0,
              $urandom_range(0, 24) == 0,
              $urandom_range(0, 9) < 5,
              $urandom_range(0, 9) < 4);
      end
      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/tug_of_war_field.md
Name: tug_of_war_field

Overview:
- Parametrised successor to the single-cell playfield light: one block owns the whole N-light tug-of-war track instead of N chained per-light cells.
- Tracks a single lit position, moves it on player key presses and detects a round win when the light is pushed off an end.
- Keeps per-player saturating win counters and sits between the key-input conditioning and the LED/HEX display drivers.

Parameters:
- NUM_LIGHTS, 9, number of track lights; must be odd and >= 3.
- SCORE_W, 3, width of each player's win counter.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-low reset: low at a rising clk edge clears all state.
- res  input  1  round restart, active-high, synchronous: recentres the light and keeps scores.
- L  input  1  left player key, active-high, synchronous to clk.
- R  input  1  right player key, active-high, synchronous to clk.
- lights  output  NUM_LIGHTS  one-hot track display; bit NUM_LIGHTS-1 is leftmost, bit 0 is rightmost.
- left_win  output  1  high while the round is won by the left player.
- right_win  output  1  high while the round is won by the right player.
- left_score  output  SCORE_W  left player's round wins.
- right_score  output  SCORE_W  right player's round wins.

Behaviour:
- Internal position register pos, range 0..NUM_LIGHTS-1. CENTER = (NUM_LIGHTS-1)/2.
- Each accepted press is called a move event; see Optional Feature for how L/R become events.
- FSM states: PLAY, LWIN, RWIN.
- Reset (reset==0 at edge):
  - state=PLAY, pos=CENTER, both scores=0.
  - Outputs after that edge: lights = one-hot at CENTER; left_win=0; right_win=0; both scores 0.
  - Reset overrides res and all key activity, including a reset asserted mid-round or during a win state.
- res (reset==1, res==1):
  - state=PLAY, pos=CENTER, scores unchanged.
  - Overrides any move event in the same cycle.
- PLAY state, on a move event:
  - L only and pos < NUM_LIGHTS-1: pos increments by 1.
  - L only and pos == NUM_LIGHTS-1: go to LWIN, left_score increments.
  - R only and pos > 0: pos decrements by 1.
  - R only and pos == 0: go to RWIN, right_score increments.
  - L and R in the same cycle: no move, no win (explicit tie rule; the light never goes dark).
- LWIN / RWIN states:
  - The track is frozen: all key activity is ignored and pos is held.
  - The state is left only by res or reset.
- Outputs are registered-state decodes with no combinational path from L/R:
  - lights = one-hot(pos) in PLAY, all zeros in LWIN/RWIN.
  - left_win = (state==LWIN); right_win = (state==RWIN).
- Latency: a move event at edge k is visible on lights/win/score outputs after edge k (one cycle).
- Scores saturate at 2^SCORE_W-1: a further win still enters the win state, but the counter holds.
- Invariant: exactly one lights bit is high in PLAY; the win flags are mutually exclusive.

Optional Feature:
- Macro: TOW_KEY_EDGE_EN.
- Defined:
  - L and R each pass through an internal registered rising-edge detector; a move event is a 0->1 transition, so holding a key moves the light once.
  - Detector registers clear to 0 on reset; a key already high when reset is released does not generate an event.
  - The edge detector adds no extra output latency: the event is taken on the same edge the new key level is sampled.
- Undefined:
  - A move event is the key level itself: every cycle L or R is high counts as one event.
  - This mode is for benches and for inputs that are already edge-conditioned upstream.

Test Plan:
- Reset then idle: reset=0 for 1 cycle, then reset=1, L=R=0 for 3 cycles -> lights=9'b000010000, win flags 0, scores 0.
- Left march (edge mode): 4 separate L pulses -> lights=9'b100000000. A 5th L pulse -> lights=0, left_win=1, left_score=1. Further L/R pulses -> outputs unchanged.
- Tie and hold (edge mode): L held high 5 cycles -> lights move one step only (9'b000100000). L=R=1 pulse from centre -> no movement.
- Round restart: from RWIN with right_score=1, pulse res while R=1 -> lights=9'b000010000, right_win=0, right_score stays 1.
- Saturation (SCORE_W=2): 4 left wins, each followed by res -> left_score=3 after the 3rd and 4th wins; left_win still asserts on the 4th.
- Reset mid-operation: reset=0 while pos=7 with left_score=2 -> next cycle lights=center one-hot, scores 0. With the macro undefined, L held high 5 cycles after reset -> left_win=1 on the 5th edge.
